// File: rtl/alu_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module : alu_arbiter_pkg
// Brief  : Shared ALU opcodes, arbiter state encoding and owner-mask helper
//          used by the ALU arbiter, its interface and its testbench.
// Rev    : 1.0  initial release
// ============================================================================
package alu_arbiter_pkg;

    localparam int OPID_WIDTH = 4;

    // ALU opcodes. NOP sits on an unused code so the ALU falls into its
    // default branch and holds out/z/c.
    localparam logic [OPID_WIDTH-1:0] ALU_OP_ADD = 4'd0;
    localparam logic [OPID_WIDTH-1:0] ALU_OP_ADC = 4'd1;
    localparam logic [OPID_WIDTH-1:0] ALU_OP_SUB = 4'd2;
    localparam logic [OPID_WIDTH-1:0] ALU_OP_SBC = 4'd3;
    localparam logic [OPID_WIDTH-1:0] ALU_OP_AND = 4'd4;
    localparam logic [OPID_WIDTH-1:0] ALU_OP_OR  = 4'd5;
    localparam logic [OPID_WIDTH-1:0] ALU_OP_XOR = 4'd6;
    localparam logic [OPID_WIDTH-1:0] ALU_OP_RLC = 4'd7;
    localparam logic [OPID_WIDTH-1:0] ALU_OP_RRC = 4'd8;
    localparam logic [OPID_WIDTH-1:0] ALU_OP_NOP = 4'd15;

    typedef enum logic [1:0] {
        ST_FREE = 2'd0,
        ST_OWN0 = 2'd1,
        ST_OWN1 = 2'd2
    } arb_state_e;

    // Ports allowed to be granted in a given state (bit N = port N).
    function automatic logic [1:0] owner_mask(input arb_state_e s);
        logic [1:0] m;
        case (s)
            ST_OWN0: m = 2'b01;
            ST_OWN1: m = 2'b10;
            default: m = 2'b11;
        endcase
        return m;
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module : alu_arbiter_if
// Brief  : Bundle of the two requester channels, the two response channels,
//          the shared-ALU connection and the sticky lock-timeout flag.
//          slave  : arbiter side
//          master : requesters / ALU / environment side
// Rev    : 1.0  initial release
// ============================================================================
interface alu_arbiter_if #(
    parameter int BITS   = 16,
    parameter int OPID_W = alu_arbiter_pkg::OPID_WIDTH
);
    // requester 0 / 1
    logic              req0_valid, req0_ready, req0_lock;
    logic [OPID_W-1:0] req0_op_id;
    logic [BITS-1:0]   req0_op1, req0_op2;
    logic              req1_valid, req1_ready, req1_lock;
    logic [OPID_W-1:0] req1_op_id;
    logic [BITS-1:0]   req1_op1, req1_op2;
    // responses
    logic              resp0_valid, resp0_z, resp0_c;
    logic [BITS-1:0]   resp0_out;
    logic              resp1_valid, resp1_z, resp1_c;
    logic [BITS-1:0]   resp1_out;
    // shared ALU
    logic [OPID_W-1:0] alu_op_id;
    logic [BITS-1:0]   alu_op1, alu_op2, alu_out;
    logic              alu_z, alu_c;
    // status
    logic              lock_tmo;

    modport slave (
        input  req0_valid, req0_lock, req0_op_id, req0_op1, req0_op2,
        input  req1_valid, req1_lock, req1_op_id, req1_op1, req1_op2,
        output req0_ready, req1_ready,
        output resp0_valid, resp0_out, resp0_z, resp0_c,
        output resp1_valid, resp1_out, resp1_z, resp1_c,
        output alu_op_id, alu_op1, alu_op2,
        input  alu_out, alu_z, alu_c,
        output lock_tmo
    );

    modport master (
        output req0_valid, req0_lock, req0_op_id, req0_op1, req0_op2,
        output req1_valid, req1_lock, req1_op_id, req1_op1, req1_op2,
        input  req0_ready, req1_ready,
        input  resp0_valid, resp0_out, resp0_z, resp0_c,
        input  resp1_valid, resp1_out, resp1_z, resp1_c,
        input  alu_op_id, alu_op1, alu_op2,
        output alu_out, alu_z, alu_c,
        input  lock_tmo
    );
endinterface
`default_nettype wire

// File: rtl/alu_arbiter_rr_arb2.sv
`default_nettype none
// ============================================================================
// Module : rr_arb2
// Brief  : Two-way round-robin grant. Only ports enabled by mask_i compete;
//          on a tie the port that did not win last time is granted.
// Ports  : valid_i      requests (bit N = port N)
//          last_grant_i port granted most recently
//          mask_i       ports eligible in the current arbiter state
//          grant_o      one-hot (or zero) grant
// Rev    : 1.0  initial release
// ============================================================================
module rr_arb2 (
    input  logic [1:0] valid_i,
    input  logic       last_grant_i,
    input  logic [1:0] mask_i,
    output logic [1:0] grant_o
);
    logic [1:0] w_elig;

    assign w_elig = valid_i & mask_i;

    always_comb begin
        grant_o = w_elig;
        if (&w_elig) begin
            grant_o = last_grant_i ? 2'b01 : 2'b10;
        end
    end
endmodule
`default_nettype wire

// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module : alu_arbiter
// Brief  : Shares one registered ALU between two requesters with round-robin
//          arbitration and a carry-chain lock. Issue is combinational; the
//          response is returned to the issuing port one cycle later.
// Ports  : clk    clock, posedge
//          reset  asynchronous, active-high
//          bus    alu_arbiter_if.slave: request/response channels, ALU
//                 connection and sticky lock_tmo flag
// Params : BITS      datapath width
//          LOCK_TMO  owner idle cycles before a lock is forced free (0=never)
// Rev    : 1.0  initial release
// ============================================================================
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int BITS     = 16,
    parameter int LOCK_TMO = 64
) (
    input  logic          clk,
    input  logic          reset,
    alu_arbiter_if.slave  bus
);
    localparam int              CNT_W   = (LOCK_TMO > 0) ? $clog2(LOCK_TMO + 1) : 1;
    localparam logic [CNT_W:0]  TMO_LIM = (CNT_W + 1)'(LOCK_TMO);

    arb_state_e       state_q, state_d;
    logic             last_grant_q, last_grant_d;
    logic             resp_pending_q, resp_owner_q;
    logic             lock_tmo_q, lock_tmo_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [1:0]            w_valid, w_grant_raw, w_grant;
    logic                  w_issue, w_issue_port, w_issue_lock;
    logic                  w_owner_idle, w_tmo_hit;
    logic [OPID_WIDTH-1:0] w_op_id;
    logic [BITS-1:0]       w_op1, w_op2;

    assign w_valid = {bus.req1_valid, bus.req0_valid};

    rr_arb2 u_rr_arb2 (
        .valid_i      (w_valid),
        .last_grant_i (last_grant_q),
        .mask_i       (owner_mask(state_q)),
        .grant_o      (w_grant_raw)
    );

    // Nothing is accepted while reset is held, so ready reads 0 in reset.
    assign w_grant      = reset ? 2'b00 : w_grant_raw;
    assign w_issue      = |w_grant;
    assign w_issue_port = w_grant[1];
    assign w_issue_lock = w_grant[1] ? bus.req1_lock : bus.req0_lock;

    assign bus.req0_ready = w_grant[0];
    assign bus.req1_ready = w_grant[1];

    // With no grant the ALU sees NOP and keeps out/z/c untouched.
    always_comb begin
        w_op_id = ALU_OP_NOP;
        w_op1   = '0;
        w_op2   = '0;
        if (w_grant[0]) begin
            w_op_id = bus.req0_op_id;
            w_op1   = bus.req0_op1;
            w_op2   = bus.req0_op2;
        end else if (w_grant[1]) begin
            w_op_id = bus.req1_op_id;
            w_op1   = bus.req1_op1;
            w_op2   = bus.req1_op2;
        end
    end

    assign bus.alu_op_id = w_op_id;
    assign bus.alu_op1   = w_op1;
    assign bus.alu_op2   = w_op2;

    assign w_owner_idle = ((state_q == ST_OWN0) && !bus.req0_valid) ||
                          ((state_q == ST_OWN1) && !bus.req1_valid);

    // Fires on the idle cycle whose increment would reach LOCK_TMO, so the
    // other port can be granted on the very next idle cycle.
    assign w_tmo_hit = (LOCK_TMO != 0) && w_owner_idle &&
                       (({1'b0, cnt_q} + 1'b1) == TMO_LIM);

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        lock_tmo_d   = lock_tmo_q;
        if (w_issue) begin
            last_grant_d = w_issue_port;
            cnt_d        = '0;
            if (w_issue_lock) begin
                state_d = w_issue_port ? ST_OWN1 : ST_OWN0;
            end else begin
                state_d = ST_FREE;
            end
        end else if (w_tmo_hit) begin
            state_d    = ST_FREE;
            cnt_d      = '0;
            lock_tmo_d = 1'b1;
        end else if (w_owner_idle) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= ST_FREE;
            last_grant_q   <= 1'b1;
            resp_pending_q <= 1'b0;
            resp_owner_q   <= 1'b0;
            lock_tmo_q     <= 1'b0;
            cnt_q          <= '0;
        end else begin
            state_q        <= state_d;
            last_grant_q   <= last_grant_d;
            resp_pending_q <= w_issue;
            resp_owner_q   <= w_issue_port;
            lock_tmo_q     <= lock_tmo_d;
            cnt_q          <= cnt_d;
        end
    end

    // The ALU registered the op at the end of the issue cycle; its outputs
    // now belong to whoever issued.
    assign bus.resp0_valid = resp_pending_q && !resp_owner_q;
    assign bus.resp1_valid = resp_pending_q &&  resp_owner_q;
    assign bus.resp0_out   = bus.alu_out;
    assign bus.resp0_z     = bus.alu_z;
    assign bus.resp0_c     = bus.alu_c;
    assign bus.resp1_out   = bus.alu_out;
    assign bus.resp1_z     = bus.alu_z;
    assign bus.resp1_c     = bus.alu_c;
    assign bus.lock_tmo    = lock_tmo_q;
endmodule
`default_nettype wire
